parity_rx: RTL

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx_pkg.sv | 20 ++
 rtl/parity_acc.sv | 23 ++
 rtl/parity_rx.sv | 116 +++++++++++
 3 files changed

// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the parity_rx serial frame receiver.
// Frame on the line: start(0), DATA_W data bits LSB first, parity, stop(1).
package parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // The accumulator holds XOR(data bits, parity bit); its target value is the parity mode.
  function automatic logic parity_good(input logic acc, input logic odd_mode);
    return acc == odd_mode;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// Running XOR accumulator for the parity check; clear wins over enable.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic p
);

  logic r_p;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_p <= 1'b0;
    end else if (en) begin
      r_p <= r_p ^ d;
    end
  end

  assign p = r_p;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver with parity and stop-bit checking; one result pulse per frame.
// Line bits are only consumed on cycles where rx_valid is high.
module parity_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_parity_err;
  logic                r_frame_err;

  logic                w_start;
  logic                w_acc_en;
  logic                w_acc_p;
  logic                w_last_bit;
  logic [DATA_W-1:0]   w_shift_next;

  assign w_start    = rx_valid && (r_state == IDLE) && (rx_bit == START_BIT);
  assign w_acc_en   = rx_valid && ((r_state == DATA) || (r_state == PARITY));
  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  // LSB arrives first, so new bits enter at the top and walk down to bit 0.
  always_comb begin
    w_shift_next = r_shift;
    for (int i = 0; i < DATA_W - 1; i++) begin
      w_shift_next[i] = r_shift[i+1];
    end
    w_shift_next[DATA_W-1] = rx_bit;
  end

  parity_acc u_acc (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .en  (w_acc_en),
    .d   (rx_bit),
    .p   (w_acc_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          IDLE: begin
            if (rx_bit == START_BIT) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shift <= w_shift_next;
            if (w_last_bit) begin
              r_state <= PARITY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PARITY: begin
            r_state <= STOP;
          end
          STOP: begin
            // Always back to IDLE: a low stop bit is a framing error, never a new start.
            r_state <= IDLE;
            if (rx_bit != STOP_BIT) begin
              r_frame_err <= 1'b1;
            end else if (parity_good(w_acc_p, 1'(PARITY_ODD))) begin
              r_data_valid <= 1'b1;
              r_data_out   <= r_shift;
            end else begin
              r_parity_err <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule
